// File: rtl/sent_pkg.sv
// Shared constants, CRC helpers and FSM state type for the SENT transmit channel.
package sent_pkg;

    localparam logic [1:0] NO_PAUSE       = 2'd0;
    localparam logic [1:0] FIXED_PAUSE    = 2'd1;
    localparam logic [1:0] VARIABLE_PAUSE = 2'd2;
    localparam logic       LEGACY_CRC     = 1'b0;
    localparam logic       RECOMMEND_CRC  = 1'b1;

    // Entry i lives at bits [4*i +: 4]; listed from index 15 down to 0.
    localparam logic [63:0] CRC_TABLE = {4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
                                         4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0};
    localparam logic [3:0]  CRC_SEED  = 4'd5;

    localparam logic [9:0] SYNC_TICKS     = 10'd56;
    localparam logic [9:0] NIB_BASE_TICKS = 10'd12;

    localparam logic [7:0]  CTICK_MIN = 8'd3;
    localparam logic [7:0]  CTICK_MAX = 8'd90;
    localparam logic [7:0]  LTICK_MIN = 8'd4;
    localparam logic [7:0]  LTICK_MAX = 8'd11;
    localparam logic [15:0] PLEN_MIN  = 16'd12;
    localparam logic [15:0] PLEN_MAX  = 16'd768;
    localparam logic [9:0]  PAUSE_MIN = 10'd12;

    localparam logic [7:0] DEF_CTICK = 8'd3;
    localparam logic [3:0] DEF_LTICK = 4'd5;
    localparam logic [1:0] DEF_MODE  = NO_PAUSE;
    localparam logic [9:0] DEF_PLEN  = 10'd12;
    localparam logic       DEF_CRC   = LEGACY_CRC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SYNC,
        ST_NIB,
        ST_PAUSE
    } sent_state_e;

    function automatic logic [3:0] crc_tab(input logic [3:0] idx);
        return CRC_TABLE[{idx, 2'b00} +: 4];
    endfunction

    // Data nibbles D1..D6 only, D1 (bits 23:20) first; status is not covered.
    function automatic logic [3:0] crc4(input logic [23:0] data, input logic mode);
        logic [3:0] c;
        c = CRC_SEED;
        for (int i = 5; i >= 0; i--) c = data[i*4 +: 4] ^ crc_tab(c);
        if (mode == RECOMMEND_CRC) c = crc_tab(c);
        return c;
    endfunction

    function automatic logic [9:0] frame_ticks(input logic [27:0] word, input logic [3:0] crc);
        logic [9:0] t;
        t = SYNC_TICKS + 10'd96 + {6'd0, crc};
        for (int i = 0; i < 7; i++) t = t + {6'd0, word[i*4 +: 4]};
        return t;
    endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// Programmable tick divider: tick_o pulses on the last clock of each period.
module sent_tick_gen #(
    parameter int TICK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart_i,
    input  logic [TICK_CNT_W-1:0] period_i,
    output logic                  tick_o
);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == period_i - TICK_CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q + TICK_CNT_W'(1);
        if (restart_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sent_tx_channel.sv
// One SENT transmit channel: pops frame words from its FIFO and drives sync,
// status, six data nibbles, CRC and optional pause onto the idle-high line.
module sent_tx_channel
    import sent_pkg::*;
#(
    parameter int CLK_FREQ   = 10000000,
    parameter int TICK_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_ctick_len,
    input  logic [7:0]  cfg_ltick_len,
    input  logic [1:0]  cfg_pause_mode,
    input  logic [15:0] cfg_pause_len,
    input  logic        cfg_crc_mode,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    output logic        sent_o,
    output logic        busy,
    output logic        frame_done,
    output sent_state_e dbg_state_o
);

    localparam int CLKS_PER_US = CLK_FREQ / 1000000;

    sent_state_e state_q, state_d;
    logic [27:0] word_q, word_d;
    logic [3:0]  crc_q, crc_d;
    logic [2:0]  nib_idx_q, nib_idx_d;
    logic [9:0]  sym_cnt_q, sym_cnt_d;
    logic [9:0]  pause_ticks_q, pause_ticks_d;
    logic [7:0]  act_ctick_q, act_ctick_d;
    logic [3:0]  act_ltick_q, act_ltick_d;
    logic [1:0]  act_mode_q, act_mode_d;
    logic        sent_q, sent_d;
    logic        frame_done_q, frame_done_d;

    logic [7:0]  shd_ctick_q, shd_ctick_d;
    logic [3:0]  shd_ltick_q, shd_ltick_d;
    logic [1:0]  shd_mode_q, shd_mode_d;
    logic [9:0]  shd_plen_q, shd_plen_d;
    logic        shd_crc_q, shd_crc_d;

    logic [3:0]  crc_new, cur_nib;
    logic [9:0]  ft_new, pause_new, sym_len;
    logic        tick, restart, rd_en, line_active;
    logic [TICK_CNT_W-1:0] period;
    logic        unused_hi;

    assign unused_hi   = ^fifo_dout[31:28];
    assign period      = TICK_CNT_W'(act_ctick_q) * TICK_CNT_W'(CLKS_PER_US);
    assign fifo_rd_en  = rd_en & ~rst;
    assign busy        = (state_q != ST_IDLE) | fifo_rd_en;
    assign sent_o      = sent_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

    sent_tick_gen #(.TICK_CNT_W(TICK_CNT_W)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .period_i  (period),
        .tick_o    (tick)
    );

    // Shadow config with clamping; a pause mode of 3 collapses to no pause.
    always_comb begin
        shd_ctick_d = shd_ctick_q;
        shd_ltick_d = shd_ltick_q;
        shd_mode_d  = shd_mode_q;
        shd_plen_d  = shd_plen_q;
        shd_crc_d   = shd_crc_q;
        if (cfg_valid) begin
            if (cfg_ctick_len < CTICK_MIN)      shd_ctick_d = CTICK_MIN;
            else if (cfg_ctick_len > CTICK_MAX) shd_ctick_d = CTICK_MAX;
            else                                shd_ctick_d = cfg_ctick_len;
            if (cfg_ltick_len < LTICK_MIN)      shd_ltick_d = 4'(LTICK_MIN);
            else if (cfg_ltick_len > LTICK_MAX) shd_ltick_d = 4'(LTICK_MAX);
            else                                shd_ltick_d = 4'(cfg_ltick_len);
            if (cfg_pause_len < PLEN_MIN)       shd_plen_d  = 10'(PLEN_MIN);
            else if (cfg_pause_len > PLEN_MAX)  shd_plen_d  = 10'(PLEN_MAX);
            else                                shd_plen_d  = 10'(cfg_pause_len);
            shd_mode_d = (cfg_pause_mode == 2'd3) ? NO_PAUSE : cfg_pause_mode;
            shd_crc_d  = cfg_crc_mode;
        end
    end

    // Frame-constant values, evaluated against the word arriving in LOAD.
    always_comb begin
        crc_new = crc4(fifo_dout[23:0], shd_crc_d);
        ft_new  = frame_ticks(fifo_dout[27:0], crc_new);
        if (shd_mode_d == FIXED_PAUSE)           pause_new = shd_plen_d;
        else if (shd_plen_d >= ft_new + 10'd12)  pause_new = shd_plen_d - ft_new;
        else                                     pause_new = PAUSE_MIN;
    end

    always_comb begin
        cur_nib = crc_q;
        if (nib_idx_q != 3'd7) cur_nib = word_q[4*(6 - int'(nib_idx_q)) +: 4];
        case (state_q)
            ST_NIB:   sym_len = NIB_BASE_TICKS + {6'd0, cur_nib};
            ST_PAUSE: sym_len = pause_ticks_q;
            default:  sym_len = SYNC_TICKS;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        crc_d         = crc_q;
        nib_idx_d     = nib_idx_q;
        sym_cnt_d     = sym_cnt_q;
        pause_ticks_d = pause_ticks_q;
        act_ctick_d   = act_ctick_q;
        act_ltick_d   = act_ltick_q;
        act_mode_d    = act_mode_q;
        restart       = 1'b0;
        rd_en         = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                word_d        = fifo_dout[27:0];
                crc_d         = crc_new;
                pause_ticks_d = pause_new;
                act_ctick_d   = shd_ctick_d;
                act_ltick_d   = shd_ltick_d;
                act_mode_d    = shd_mode_d;
                restart       = 1'b1;
                sym_cnt_d     = '0;
                nib_idx_d     = '0;
                state_d       = ST_SYNC;
            end
            ST_SYNC, ST_NIB, ST_PAUSE: begin
                if (tick) begin
                    if (sym_cnt_q != sym_len - 10'd1) begin
                        sym_cnt_d = sym_cnt_q + 10'd1;
                    end else begin
                        sym_cnt_d = '0;
                        if (state_q == ST_SYNC) begin
                            state_d = ST_NIB;
                        end else if (state_q == ST_NIB && nib_idx_q != 3'd7) begin
                            nib_idx_d = nib_idx_q + 3'd1;
                        end else if (state_q == ST_NIB && act_mode_q != NO_PAUSE) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d      = ST_IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Line level is registered from next-state values so it only moves on ticks.
        line_active = (state_d == ST_SYNC) || (state_d == ST_NIB) || (state_d == ST_PAUSE);
        sent_d      = !(line_active && (sym_cnt_d < {6'd0, act_ltick_d}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            word_q        <= '0;
            crc_q         <= '0;
            nib_idx_q     <= '0;
            sym_cnt_q     <= '0;
            pause_ticks_q <= PAUSE_MIN;
            act_ctick_q   <= DEF_CTICK;
            act_ltick_q   <= DEF_LTICK;
            act_mode_q    <= DEF_MODE;
            sent_q        <= 1'b1;
            frame_done_q  <= 1'b0;
            shd_ctick_q   <= DEF_CTICK;
            shd_ltick_q   <= DEF_LTICK;
            shd_mode_q    <= DEF_MODE;
            shd_plen_q    <= DEF_PLEN;
            shd_crc_q     <= DEF_CRC;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            crc_q         <= crc_d;
            nib_idx_q     <= nib_idx_d;
            sym_cnt_q     <= sym_cnt_d;
            pause_ticks_q <= pause_ticks_d;
            act_ctick_q   <= act_ctick_d;
            act_ltick_q   <= act_ltick_d;
            act_mode_q    <= act_mode_d;
            sent_q        <= sent_d;
            frame_done_q  <= frame_done_d;
            shd_ctick_q   <= shd_ctick_d;
            shd_ltick_q   <= shd_ltick_d;
            shd_mode_q    <= shd_mode_d;
            shd_plen_q    <= shd_plen_d;
            shd_crc_q     <= shd_crc_d;
        end
    end

endmodule

// File: doc/sent_tx_channel.md
Name: sent_tx_channel

Overview:
Single-channel SAE J2716 SENT transmitter. It sits downstream of the per-channel SENT data FIFO and parameter registers inside sent_top; one instance per channel (SENT_NUM instances).
It pops 32-bit frame words from its FIFO and encodes each into one SENT frame on an open-drain-style line: sync, status, 6 data nibbles, CRC nibble and an optional pause pulse.
Configuration written by the UDP parameter-frame decoder is latched and applied at frame boundaries only.

Parameters:
CLK_FREQ, 10000000, module clock frequency in Hz; CLKS_PER_US = CLK_FREQ/1000000.
TICK_CNT_W, 16, width of the clock-per-tick counter; must hold 90*CLKS_PER_US.

Ports:
clk  in  1  module clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  one-cycle strobe; cfg_* fields valid
cfg_ctick_len  in  8  tick length in us, legal 3..90
cfg_ltick_len  in  8  low-pulse ticks per symbol, legal 4..11
cfg_pause_mode  in  2  0 no pause, 1 fixed, 2 variable, 3 treated as 0
cfg_pause_len  in  16  pause ticks (fixed) or total frame ticks (variable), legal 12..768
cfg_crc_mode  in  1  0 legacy, 1 recommended
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop strobe
fifo_dout  in  32  frame word, valid the cycle after fifo_rd_en
sent_o  out  1  SENT line, idle high
busy  out  1  high from the pop until the end of the frame (including pause)
frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset values: sent_o=1, fifo_rd_en=0, busy=0, frame_done=0, state IDLE.
- Config defaults at reset: ctick=3, ltick=5, mode=0, pause_len=12, crc=legacy.
- Reset asserted mid-frame: sent_o returns high immediately (asynchronous). The partial frame is lost and the word is not re-popped.
- cfg_valid updates the shadow config, with these clamps:
  - ctick clamped to 3..90
  - ltick clamped to 4..11
  - pause_len clamped to 12..768
- Shadow config is copied to active config only in LOAD. A cfg_valid during a frame therefore takes effect from the next frame. If cfg_valid and LOAD coincide, the new value is used.
- Frame word format: [31:28] ignored, [27:24] status nibble, [23:20] D1 … [3:0] D6. D1 is transmitted first.
- Tick generator: counts 0..ctick*CLKS_PER_US-1 and emits a tick at wrap. It restarts at the start of SYNC.
- Symbol of N ticks: sent_o low for ltick ticks, then high for N-ltick ticks.
  - SYNC: N = 56.
  - Nibble v: N = 12+v.
  - PAUSE: N = pause ticks.
- CRC (4-bit, seed 5, table-driven): for each data nibble d, crc = d ^ T[crc]. Status is excluded.
  - Recommended mode additionally performs crc = T[crc] (augment with a zero nibble).
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
  - The CRC is computed in LOAD over 6 nibbles. It may be sequential only if it completes before the CRC symbol starts.
- Pause ticks:
  - Mode 1: pause_len.
  - Mode 2: pause_len − frame_ticks, where frame_ticks = 56 + Σ(12+nibble) over status, D1..D6 and CRC. If the result is < 12 it is forced to 12.
- FSM:
  - IDLE: if !fifo_empty → FETCH, asserting fifo_rd_en for 1 cycle.
  - FETCH: wait 1 cycle → LOAD.
  - LOAD: capture the word, CRC and active config → SYNC. sent_o falls on the first cycle of SYNC.
  - SYNC → NIB (index 0..7: status, D1..D6, CRC) → PAUSE if mode≠0, else end.
  - End of frame: frame_done pulses. If !fifo_empty, go to FETCH (the next sync starts 3 cycles after the last high cycle); otherwise go to IDLE.
- Line never glitches: sent_o changes only on tick boundaries, except in response to reset.

Decomposition:
- Package sent_pkg:
  - pause-mode constants NO_PAUSE/FIXED_PAUSE/VARIABLE_PAUSE and CRC-mode constants LEGACY_CRC/RECOMMEND_CRC
  - CRC4 table T and seed 5
  - SYNC_TICKS=56 and NIB_BASE_TICKS=12
  - clamp limits and reset defaults
  - FSM state typedef
- One natural sub-module: sent_tick_gen (programmable tick divider with restart input).

Test Plan:
- All cases use CLK_FREQ 10 MHz and word 0x6A654321.
- Fixed pause: cfg(ctick 10, ltick 5, fixed 20, legacy) → CRC nibble 4.
  - Sync = 5600 clks, first 500 clks low.
  - Status = 2200 clks, D1..D6 = 1800/1700/1600/1500/1400/1300 clks, CRC = 1600 clks.
  - Pause = 2000 clks; frame_done 20700 clks after sync falls.
- Variable pause, clamped: cfg(ctick 5, ltick 5, variable 30, recommended) → CRC 0xE (26 ticks), frame 197 ticks; pause clamped to 12 ticks; total 209 ticks = 10450 clks.
- Variable pause, unclamped: same config but pause_len 250 → pause = 53 ticks (2650 clks); total exactly 250 ticks = 12500 clks.
- Clamping: cfg ctick 2, ltick 2, pause_len 5 → behaves as ctick 3, ltick 4, pause 12. Sync = 56×30 clks with 120-clk low.
- Config mid-frame: cfg_valid during D3 of frame 1 → frame 1 timing unchanged; frame 2 uses the new config. Two queued words → second sync falls 3 cycles after frame_done.
- Reset mid-frame: assert rst during a low phase of D2 → sent_o=1 same cycle, busy=0; after release with empty FIFO, line stays high and fifo_rd_en stays 0.
